// File: rtl/multi_cycle_cpu_112.sv
// multi_cycle_cpu_112
// Multi-cycle MIPS-subset core. A single FSM re-sequences the classic
// control-signal set so each instruction takes 2-5 cycles, and one ALU is
// shared between the FETCH-time PC increment and the EXEC-time operation
// (including the beq target). Undefined opcodes/functs park the core in HALT.
//
// Ports
//   clk        in   single clock, rising-edge state updates
//   rst_n      in   asynchronous active-low reset
//   pc         out  program counter (byte address)
//   state      out  FSM state (FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7)
//   halted     out  high while in HALT
//   retired    out  completed-instruction count, wraps modulo 2^32
//   dbg_we     out  register-file write strobe (cycle after WB edge)
//   dbg_waddr  out  register index written
//   dbg_wdata  out  value written
module multi_cycle_cpu_112 #(
  parameter int    IMEM_AW   = 10,
  parameter int    DMEM_AW   = 10,
  parameter string IMEM_INIT = "prog.hex"
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired,
  output logic        dbg_we,
  output logic [4:0]  dbg_waddr,
  output logic [31:0] dbg_wdata
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Memories: IMEM is read-only at run time, DMEM is never reset.
  logic [31:0] imem [0:(2**IMEM_AW)-1];
  logic [31:0] dmem [0:(2**DMEM_AW)-1];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] retired_q, retired_d;
  logic        dbg_we_q, dbg_we_d;
  logic [4:0]  dbg_waddr_q, dbg_waddr_d;
  logic [31:0] dbg_wdata_q, dbg_wdata_d;
  logic [31:0] rf_q [32];

  // Instruction fields
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [15:0] imm_s;
  logic [31:0] sext_s, zext_s, ext_imm_s;

  assign op_s    = ir_q[31:26];
  assign rs_s    = ir_q[25:21];
  assign rt_s    = ir_q[20:16];
  assign rd_s    = ir_q[15:11];
  assign funct_s = ir_q[5:0];
  assign imm_s   = ir_q[15:0];
  assign sext_s  = {{16{imm_s[15]}}, imm_s};
  assign zext_s  = {16'd0, imm_s};

  // Control signals
  logic       reg_wr_s, reg_dst_s, ext_op_s, alu_src_s;
  logic [2:0] alu_ctr_s;
  logic       mem_wr_s, mem_to_reg_s, branch_s, jump_s, is_mem_s, valid_s;

  // Main decoder: IR -> control vocabulary; anything unlisted is invalid.
  always_comb begin
    reg_wr_s     = 1'b0;
    reg_dst_s    = 1'b0;
    ext_op_s     = 1'b0;
    alu_src_s    = 1'b0;
    alu_ctr_s    = ALU_ADD;
    mem_wr_s     = 1'b0;
    mem_to_reg_s = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    is_mem_s     = 1'b0;
    valid_s      = 1'b1;
    case (op_s)
      OP_RTYPE: begin
        reg_wr_s  = 1'b1;
        reg_dst_s = 1'b1;
        case (funct_s)
          FN_ADDU: alu_ctr_s = ALU_ADD;
          FN_SUBU: alu_ctr_s = ALU_SUB;
          FN_AND:  alu_ctr_s = ALU_AND;
          FN_OR:   alu_ctr_s = ALU_OR;
          FN_SLT:  alu_ctr_s = ALU_SLT;
          default: valid_s   = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        reg_wr_s  = 1'b1;
        ext_op_s  = 1'b1;
        alu_src_s = 1'b1;
      end
      OP_ORI: begin
        reg_wr_s  = 1'b1;
        alu_src_s = 1'b1;
        alu_ctr_s = ALU_OR;
      end
      OP_LW: begin
        reg_wr_s     = 1'b1;
        ext_op_s     = 1'b1;
        alu_src_s    = 1'b1;
        mem_to_reg_s = 1'b1;
        is_mem_s     = 1'b1;
      end
      OP_SW: begin
        ext_op_s  = 1'b1;
        alu_src_s = 1'b1;
        mem_wr_s  = 1'b1;
        is_mem_s  = 1'b1;
      end
      OP_BEQ:  branch_s = 1'b1;
      OP_J:    jump_s   = 1'b1;
      default: valid_s  = 1'b0;
    endcase
  end

  assign ext_imm_s = ext_op_s ? sext_s : zext_s;

  // Shared ALU operand select: PC+4 outside EXEC, branch target or datapath op in EXEC.
  logic [31:0] alu_a_s, alu_b_s, alu_res_s;
  logic [2:0]  alu_op_s;

  always_comb begin
    alu_a_s  = pc_q;
    alu_b_s  = 32'd4;
    alu_op_s = ALU_ADD;
    if (state_q == S_EXEC) begin
      if (branch_s) begin
        // pc already holds the fall-through address from FETCH
        alu_b_s = {sext_s[29:0], 2'b00};
      end else begin
        alu_a_s  = a_q;
        alu_b_s  = alu_src_s ? ext_imm_s : b_q;
        alu_op_s = alu_ctr_s;
      end
    end else begin
      alu_a_s = pc_q;
    end
  end

  // ALU
  always_comb begin
    case (alu_op_s)
      ALU_ADD: alu_res_s = alu_a_s + alu_b_s;
      ALU_SUB: alu_res_s = alu_a_s - alu_b_s;
      ALU_AND: alu_res_s = alu_a_s & alu_b_s;
      ALU_OR:  alu_res_s = alu_a_s | alu_b_s;
      ALU_SLT: alu_res_s = ($signed(alu_a_s) < $signed(alu_b_s)) ? 32'd1 : 32'd0;
      default: alu_res_s = 32'd0;
    endcase
  end

  logic [DMEM_AW-1:0] dmem_idx_s;
  logic               retire_s, rf_we_s, dmem_we_s;
  logic [4:0]         rf_waddr_s;
  logic [31:0]        rf_wdata_s;

  // Upper address bits are dropped, so data addresses wrap modulo the depth.
  assign dmem_idx_s = alu_out_q[DMEM_AW+1:2];

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    retire_s    = 1'b0;
    dbg_we_d    = 1'b0;
    dbg_waddr_d = dbg_waddr_q;
    dbg_wdata_d = dbg_wdata_q;
    rf_we_s     = 1'b0;
    rf_waddr_s  = 5'd0;
    rf_wdata_s  = 32'd0;
    dmem_we_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = imem[pc_q[IMEM_AW+1:2]];
        pc_d    = alu_res_s;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rf_q[rs_s];
        b_d = rf_q[rt_s];
        if (!valid_s) begin
          state_d = S_HALT;
        end else if (jump_s) begin
          pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (branch_s) begin
          pc_d     = (a_q == b_q) ? alu_res_s : pc_q;
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          alu_out_d = alu_res_s;
          state_d   = is_mem_s ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (mem_wr_s) begin
          dmem_we_s = 1'b1;
          retire_s  = 1'b1;
          state_d   = S_FETCH;
        end else begin
          mdr_d   = dmem[dmem_idx_s];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we_s     = reg_wr_s;
        rf_waddr_s  = reg_dst_s ? rd_s : rt_s;
        rf_wdata_s  = mem_to_reg_s ? mdr_q : alu_out_q;
        dbg_we_d    = reg_wr_s;
        dbg_waddr_d = rf_waddr_s;
        dbg_wdata_d = rf_wdata_s;
        retire_s    = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + {31'd0, retire_s};

  // Architectural and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= 32'd0;
      ir_q        <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      alu_out_q   <= 32'd0;
      mdr_q       <= 32'd0;
      retired_q   <= 32'd0;
      dbg_we_q    <= 1'b0;
      dbg_waddr_q <= 5'd0;
      dbg_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_out_q   <= alu_out_d;
      mdr_q       <= mdr_d;
      retired_q   <= retired_d;
      dbg_we_q    <= dbg_we_d;
      dbg_waddr_q <= dbg_waddr_d;
      dbg_wdata_q <= dbg_wdata_d;
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
      rf_q[rf_waddr_s] <= rf_wdata_s;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (dmem_we_s) dmem[dmem_idx_s] <= b_q;
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;
  assign dbg_we    = dbg_we_q;
  assign dbg_waddr = dbg_waddr_q;
  assign dbg_wdata = dbg_wdata_q;

endmodule

// File: tb/tb_multi_cycle_cpu_112.sv
// Bench for multi_cycle_cpu_112: an instruction-level ISA model expands each
// instruction into its expected per-cycle outputs; one compare process checks
// the DUT every cycle, and directed programs add hand-computed expectations.
module tb_multi_cycle_cpu_112;
  localparam int IAW = 7;
  localparam int DAW = 4;
  localparam int IW  = 128;
  localparam int DW  = 16;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, retired, dbg_wdata;
  logic [2:0]  state;
  logic        halted, dbg_we;
  logic [4:0]  dbg_waddr;

  multi_cycle_cpu_112 #(.IMEM_AW(IAW), .DMEM_AW(DAW), .IMEM_INIT("")) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .state(state), .halted(halted),
    .retired(retired), .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  st;
    logic [31:0] ret;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
  } snap_t;

  snap_t       exp_q[$];
  snap_t       cur_e;
  logic [31:0] prog [IW];
  logic [31:0] m_dmem [DW];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ret;
  bit          m_halt;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [2:0] st, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic mw, input logic [31:0] ma, input logic [31:0] md);
    snap_t x;
    x.pc = p; x.st = st; x.ret = m_ret; x.we = we; x.wa = wa; x.wd = wd;
    x.mw = mw; x.ma = ma; x.md = md;
    exp_q.push_back(x);
  endtask

  task automatic push_s(input logic [31:0] p, input logic [2:0] st);
    push(p, st, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Expand the instruction at m_pc into its per-cycle expected outputs.
  // Register and memory effects ride on the final snapshot and are applied when it is consumed.
  task automatic model_issue();
    logic [31:0] w, p4, se, ze, a, b, res, addr;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    bit          ok;
    if (m_halt) begin
      push_s(m_pc, 3'd7);
      return;
    end
    w  = prog[(m_pc >> 2) & 32'(IW - 1)];
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'd0, w[15:0]};
    a  = m_regs[rs];
    b  = m_regs[rt];
    p4 = m_pc + 32'd4;
    ok = 1'b1;
    res = 32'd0;
    push_s(p4, 3'd1);
    m_pc = p4;
    case (op)
      6'h00: begin
        case (fn)
          6'h21: res = a + b;
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          push_s(p4, 3'd2); push_s(p4, 3'd4); m_ret++;
          push(p4, 3'd0, 1'b1, rd, res, 1'b0, 32'd0, 32'd0);
        end
      end
      6'h09, 6'h0D: begin
        res = (op == 6'h09) ? a + se : a | ze;
        push_s(p4, 3'd2); push_s(p4, 3'd4); m_ret++;
        push(p4, 3'd0, 1'b1, rt, res, 1'b0, 32'd0, 32'd0);
      end
      6'h23: begin
        addr = a + se;
        res  = m_dmem[(addr >> 2) & 32'(DW - 1)];
        push_s(p4, 3'd2); push_s(p4, 3'd3); push_s(p4, 3'd4); m_ret++;
        push(p4, 3'd0, 1'b1, rt, res, 1'b0, 32'd0, 32'd0);
      end
      6'h2B: begin
        addr = a + se;
        push_s(p4, 3'd2); push_s(p4, 3'd3); m_ret++;
        push(p4, 3'd0, 1'b0, 5'd0, 32'd0, 1'b1, (addr >> 2) & 32'(DW - 1), b);
      end
      6'h04: begin
        push_s(p4, 3'd2);
        if (a == b) m_pc = p4 + (se << 2);
        m_ret++;
        push_s(m_pc, 3'd0);
      end
      6'h02: begin
        m_pc = {p4[31:28], w[25:0], 2'b00};
        m_ret++;
        push_s(m_pc, 3'd0);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      push_s(p4, 3'd7);
      m_halt = 1'b1;
    end
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      if (exp_q.size() == 0) model_issue();
      cur_e = exp_q.pop_front();
      chk("pc", pc, cur_e.pc);
      chk("state", {29'd0, state}, {29'd0, cur_e.st});
      chk("retired", retired, cur_e.ret);
      chk("halted", {31'd0, halted}, {31'd0, (cur_e.st == 3'd7)});
      chk("dbg_we", {31'd0, dbg_we}, {31'd0, cur_e.we});
      if (cur_e.we) begin
        chk("dbg_waddr", {27'd0, dbg_waddr}, {27'd0, cur_e.wa});
        chk("dbg_wdata", dbg_wdata, cur_e.wd);
        if (cur_e.wa != 5'd0) m_regs[cur_e.wa] = cur_e.wd;
      end
      if (cur_e.mw) m_dmem[cur_e.ma] = cur_e.md;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load_prog();
    for (int i = 0; i < IW; i++) dut.imem[i] = prog[i];
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IW; i++) prog[i] = HALT_W;
  endtask

  // Reset for 3 cycles, restart the model, and check the post-release state.
  task automatic do_reset();
    chk_en = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    m_pc = 32'd0; m_ret = 32'd0; m_halt = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_dbg_we", {31'd0, dbg_we}, 32'd0);
    chk_en = 1'b1;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fl [5];
    int         r, t;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    fl[0] = 6'h21; fl[1] = 6'h23; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
    r   = $urandom_range(0, 99);
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom());
    if (r < 38) return enc_r(rs, rt, rd, fl[$urandom_range(0, 4)]);
    if (r < 54) return enc_i(6'h09, rs, rt, imm);
    if (r < 62) return enc_i(6'h0D, rs, rt, imm);
    if (r < 72) return enc_i(6'h23, rs, rt, imm);
    if (r < 82) return enc_i(6'h2B, rs, rt, imm);
    if (r < 91) begin
      t = $urandom_range(0, 8);
      t = t - 4;
      return enc_i(6'h04, rs, rt, t[15:0]);
    end
    if (r < 96) return {6'h02, 19'd0, 7'($urandom_range(0, IW - 1))};
    return $urandom();
  endfunction

  initial begin
    for (int i = 0; i < DW; i++) begin
      m_dmem[i] = 32'h1000_0000 + 32'(i);
      dut.dmem[i] = m_dmem[i];
    end

    // ALU and memory program
    clear_prog();
    prog[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    prog[1] = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFD);
    prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);
    prog[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h23);
    prog[4] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
    prog[5] = enc_i(6'h0D, 5'd0, 5'd6, 16'hFFFF);
    prog[6] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    prog[7] = enc_i(6'h23, 5'd0, 5'd7, 16'd8);
    load_prog();
    do_reset();
    tick(1);
    chk("c1_pc", pc, 32'd4);
    chk("c1_state", {29'd0, state}, 32'd1);
    tick(11);
    chk("addu_we", {31'd0, dbg_we}, 32'd1);
    chk("addu_wa", {27'd0, dbg_waddr}, 32'd3);
    chk("addu_wd", dbg_wdata, 32'd2);
    tick(1);
    chk("we_one_cycle", {31'd0, dbg_we}, 32'd0);
    tick(3);
    chk("subu_wa", {27'd0, dbg_waddr}, 32'd4);
    chk("subu_wd", dbg_wdata, 32'hFFFF_FFF8);
    tick(4);
    chk("slt_wa", {27'd0, dbg_waddr}, 32'd5);
    chk("slt_wd", dbg_wdata, 32'd1);
    tick(4);
    chk("ori_wa", {27'd0, dbg_waddr}, 32'd6);
    chk("ori_wd", dbg_wdata, 32'h0000_FFFF);
    chk("ret_after24", retired, 32'd6);
    tick(8);
    chk("ret_c32", retired, 32'd7);
    chk("dmem_w2", dut.dmem[2], 32'd5);
    tick(1);
    chk("lw_ret_c33", retired, 32'd8);
    chk("lw_wa", {27'd0, dbg_waddr}, 32'd7);
    chk("lw_wd", dbg_wdata, 32'd5);
    tick(5);
    chk("progA_halted", {31'd0, halted}, 32'd1);

    // Control flow program
    clear_prog();
    prog[0]  = enc_i(6'h09, 5'd0, 5'd1, 16'd1);
    prog[1]  = enc_i(6'h09, 5'd0, 5'd2, 16'd1);
    prog[2]  = enc_i(6'h09, 5'd0, 5'd3, 16'd2);
    prog[3]  = enc_i(6'h09, 5'd0, 5'd0, 16'd7);
    prog[4]  = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    prog[7]  = enc_i(6'h04, 5'd1, 5'd3, 16'd5);
    prog[8]  = {6'h02, 26'h40};
    prog[64] = enc_r(5'd0, 5'd1, 5'd8, 6'h21);
    load_prog();
    do_reset();
    tick(16);
    chk("r0_wr_wa", {27'd0, dbg_waddr}, 32'd0);
    chk("r0_wr_wd", dbg_wdata, 32'd7);
    chk("pre_beq_pc", pc, 32'h10);
    tick(3);
    chk("beq_taken_pc", pc, 32'h1C);
    tick(3);
    chk("beq_nt_pc", pc, 32'h20);
    tick(2);
    chk("j_pc", pc, 32'h100);
    tick(4);
    chk("r0_read_wa", {27'd0, dbg_waddr}, 32'd8);
    chk("r0_read_wd", dbg_wdata, 32'd1);

    // Halt program, then reset out of HALT
    clear_prog();
    prog[0] = enc_i(6'h09, 5'd0, 5'd1, 16'd9);
    prog[1] = enc_i(6'h0D, 5'd0, 5'd2, 16'd3);
    prog[2] = 32'hFC00_0000;
    load_prog();
    do_reset();
    tick(10);
    chk("halt_state", {29'd0, state}, 32'd7);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", pc, 32'hC);
    chk("halt_ret", retired, 32'd2);
    tick(20);
    chk("halt_ret_frozen", retired, 32'd2);
    chk("halt_pc_frozen", pc, 32'hC);
    do_reset();
    tick(1);
    chk("unhalt_pc", pc, 32'd4);
    chk("unhalt_state", {29'd0, state}, 32'd1);

    // Reset in the MEM cycle of a store
    clear_prog();
    prog[0] = enc_i(6'h09, 5'd0, 5'd1, 16'h55);
    prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd12);
    load_prog();
    do_reset();
    tick(7);
    chk("sw_in_mem", {29'd0, state}, 32'd3);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    tick(2);
    chk("sw_lost", dut.dmem[3], 32'h1000_0003);
    do_reset();
    tick(12);
    chk("sw_done", dut.dmem[3], 32'h55);

    // Randomized programs against the model
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < IW; i++) prog[i] = rand_instr();
      load_prog();
      do_reset();
      tick(400);
    end

    chk_en = 1'b0;
    #20;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
